// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, diff = a - b - bin.
// One bit per clock, LSB first, with a registered borrow chain. A request is
// captured in IDLE, WIDTH bits are processed in RUN, and DONE presents a
// one-cycle done pulse before returning to IDLE.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the registered signed
// overflow output ovf.
//
// Handshake: a request transfers on a rising edge where start=1 and ready=1.
// ready is high only in IDLE; start at any other time is ignored and not queued.
// done pulses for one cycle when diff/bout (and ovf) are updated. Those outputs
// then hold until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // FSM state. Kept as a named signal so checkers can bind to it directly.
  state_t state;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             br;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] r_nxt;

  // Full-subtractor cell acting on the current LSBs of the operand shifters.
  always_comb begin
    a_bit  = a_sh[0];
    b_bit  = b_sh[0];
    d_bit  = a_bit ^ b_bit ^ br;
    br_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    r_nxt  = {d_bit, r_sh[WIDTH-1:1]};
  end

  // Control FSM, operand/result shifters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      br    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            r_sh  <= '0;
            cnt   <= '0;
            ready <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_nxt;
          r_sh <= r_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            // Last bit: publish the result on the same edge that processes it.
            // br here is the borrow into the MSB, br_nxt the borrow out of it.
            diff  <= r_nxt;
            bout  <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= br ^ br_nxt;
`endif
            done  <= 1'b1;
            cnt   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: self-checking bench for serial_subtractor (WIDTH=8).
// Expected results are computed by the bench and queued when a request is
// driven. They are popped and compared whenever the DUT pulses done.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         done;
  logic         ovf_obs;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Entries are {ovf, bout, diff}.
  logic [W+1:0] exp_q[$];
  int           done_times[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .diff  (diff),
    .bout  (bout),
    .done  (done)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf_obs)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf_obs = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic, signed and unsigned views.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbi);
    int u;
    int s;
    logic [31:0] uv;
    logic ob;
    u  = int'(ma) - int'(mb) - int'(mbi);
    s  = int'($signed(ma)) - int'($signed(mb)) - int'(mbi);
    uv = u;
    ob = (s > 127) || (s < -128);
    return {ob, (u < 0), uv[W-1:0]};
  endfunction

  function automatic logic [W+1:0] observed();
`ifdef SERIAL_SUB_OVF_EN
    return {ovf_obs, bout, diff};
`else
    return {1'b0, bout, diff};
`endif
  endfunction

  function automatic logic [W+1:0] mask_exp(input logic [W+1:0] e);
`ifdef SERIAL_SUB_OVF_EN
    return e;
`else
    return {1'b0, e[W:0]};
`endif
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      done_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("result", 32'(observed()), 32'(mask_exp(e)));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbi,
                        input logic [W+1:0] e);
    wait_ready();
    a     = ta;
    b     = tb;
    bin   = tbi;
    start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_done;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done",  32'(done),  32'd0);
    check("rst_diff",  32'(diff),  32'd0);
    check("rst_bout",  32'(bout),  32'd0);
    check("rst_ovf",   32'(ovf_obs), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Timed run: 0x05 - 0x03, start pulsed once at edge k.
    wait_ready();
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 8'h02});
    @(negedge clk);                              // after edge k
    start = 1'b0;
    check("t_ready_k", 32'(ready), 32'd0);
    check("t_done_k",  32'(done),  32'd0);
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);                            // after edge k+j
      check("t_ready_run", 32'(ready), 32'd0);
      check("t_done_run",  32'(done),  32'd0);
      check("t_diff_hold", 32'(diff),  32'd0);
    end
    @(negedge clk);                              // after edge k+8
    check("t_done_k8",  32'(done),  32'd1);
    check("t_ready_k8", 32'(ready), 32'd0);
    check("t_diff_k8",  32'(diff),  32'h02);
    check("t_bout_k8",  32'(bout),  32'd0);
    @(negedge clk);                              // after edge k+9
    check("t_done_k9",  32'(done),  32'd0);
    check("t_ready_k9", 32'(ready), 32'd1);
    wait_idle();

    // Directed boundary vectors with hand-derived {ovf, bout, diff}.
    run_op(8'h00, 8'h01, 1'b0, {1'b0, 1'b1, 8'hFF});
    run_op(8'h80, 8'h01, 1'b0, {1'b1, 1'b0, 8'h7F});
    run_op(8'h7F, 8'hFF, 1'b0, {1'b1, 1'b1, 8'h80});
    run_op(8'h10, 8'h0F, 1'b1, {1'b0, 1'b0, 8'h00});
    run_op(8'h00, 8'h00, 1'b1, {1'b0, 1'b1, 8'hFF});

    // Random operands against the integer model.
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rbi;
      ra  = W'($urandom_range(0, 255));
      rb  = W'($urandom_range(0, 255));
      rbi = 1'($urandom_range(0, 1));
      run_op(ra, rb, rbi, model(ra, rb, rbi));
    end

    // start during RUN is ignored: operands are not relatched.
    wait_ready();
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 8'h02});
    @(negedge clk);                              // after edge k
    start = 1'b0;
    repeat (3) @(negedge clk);                   // after edge k+3
    a = 8'hAA; b = 8'h11; start = 1'b1;          // bit 3 is processed next
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);
    check("ign_diff",  32'(diff), 32'h02);
    check("ign_queue", 32'(exp_q.size()), 32'd0);

    // Reset mid-run: no done pulse, outputs cleared.
    n_done = done_times.size();
    wait_ready();
    a = 8'hC3; b = 8'h15; bin = 1'b0; start = 1'b1;
    @(negedge clk);                              // after edge k
    start = 1'b0;
    repeat (4) @(negedge clk);                   // after edge k+4
    rst_n = 1'b0;                                // during bit 4
    #1;
    check("mr_ready", 32'(ready), 32'd1);
    check("mr_done",  32'(done),  32'd0);
    check("mr_diff",  32'(diff),  32'd0);
    check("mr_bout",  32'(bout),  32'd0);
    check("mr_ovf",   32'(ovf_obs), 32'd0);
    @(negedge clk);
    check("mr_ready_hold", 32'(ready), 32'd1);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    check("mr_no_done", 32'(done_times.size()), 32'(n_done));
    check("mr_ready_after", 32'(ready), 32'd1);

    // start held high: back-to-back operations, done every W+2 cycles.
    done_times.delete();
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] xa;
      logic [W-1:0] xb;
      logic [W+1:0] xe;
      case (i)
        0: begin xa = 8'h09; xb = 8'h04; xe = {1'b0, 1'b0, 8'h05}; end
        1: begin xa = 8'h04; xb = 8'h09; xe = {1'b0, 1'b1, 8'hFB}; end
        default: begin xa = 8'hFF; xb = 8'hFF; xe = {1'b0, 1'b0, 8'h00}; end
      endcase
      wait_ready();
      a = xa; b = xb; bin = 1'b0;
      exp_q.push_back(xe);
      @(negedge clk);                            // accepted on the edge just passed
    end
    start = 1'b0;
    wait_idle();
    check("b2b_count", 32'(done_times.size()), 32'd3);
    if (done_times.size() == 3) begin
      check("b2b_gap1", 32'(done_times[1] - done_times[0]), 32'd10);
      check("b2b_gap2", 32'(done_times[2] - done_times[1]), 32'd10);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    check("global_timeout", 32'd0, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing diff = a − b − bin, one bit per clock, LSB first, with a registered borrow chain. It is the subtract-direction counterpart of the team's combinational full adder cell and targets area-constrained datapaths where a WIDTH-bit parallel subtractor is too large. A start/ready/done handshake sequences operand capture, the serial run and result presentation.

## Interface

- WIDTH, 8, operand and result width in bits; legal range WIDTH ≥ 2.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when ready=1.
- a  input  WIDTH  minuend; sampled on the accepting edge.
- b  input  WIDTH  subtrahend; sampled on the accepting edge.
- bin  input  1  borrow-in; sampled on the accepting edge.
- ready  output  1  high in IDLE only.
- diff  output  WIDTH  result; held until the next completion.
- bout  output  1  borrow-out of the MSB; held like diff.
- done  output  1  one-cycle completion pulse.
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation

- States: IDLE, RUN, DONE.
- IDLE: ready=1. If start=1 at an edge, latch a, b and bin into the operand shift registers and the borrow flop, clear the bit counter, and go to RUN.
- RUN: each edge processes bit i = counter:
  - d_i = a_i ^ b_i ^ br.
  - br ← (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - d_i shifts into the result register.
  - The counter increments.
- After bit WIDTH−1 has been processed, go to DONE on the same edge and load diff, bout (and ovf) from the internal result. These outputs do not change during RUN.
- DONE: done=1 for exactly this one cycle; unconditionally return to IDLE on the next edge.
- start is ignored in RUN and DONE: operands are not relatched and no request is queued.
- Modulo arithmetic: diff = (a − b − bin) mod 2^WIDTH. bout=1 iff a < b + bin, treating a and b as unsigned.
- Reset (asserted at any time, including mid-run) immediately forces:
  - state = IDLE, ready = 1.
  - diff = 0, bout = 0, done = 0, ovf = 0.
  - Counter, borrow flop and shift registers cleared.
  - The interrupted operation produces no done pulse.

## Timing

- Call the edge that accepts start edge k.
  - Bits 0..WIDTH−1 are processed on edges k+1..k+WIDTH.
  - diff and bout become valid and done rises after edge k+WIDTH.
  - done falls after edge k+WIDTH+1.
- Latency from start acceptance to done is WIDTH cycles.
- ready falls after edge k and rises again after edge k+WIDTH+1.
- Throughput: with start held high, one operation per WIDTH+2 cycles. The next acceptance occurs at edge k+WIDTH+2.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration

- SERIAL_SUB_OVF_EN defined:
  - The ovf port exists.
  - ovf = (borrow into the MSB) XOR (borrow out of the MSB), i.e. the signed result is not representable in WIDTH bits.
  - ovf is registered with diff, held until the next completion, and reset to 0.
- Not defined: the ovf port and its logic are absent. All other behaviour is identical.

## Test plan

- WIDTH=8, a=0x05, b=0x03, bin=0, start pulsed at edge k → done high only in the cycle after edge k+8; diff=0x02, bout=0, ready=0 from after edge k through after edge k+8.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1; ovf=0 when SERIAL_SUB_OVF_EN is defined.
- a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1. Also a=0x7F, b=0xFF, bin=0 → diff=0x80, bout=1, ovf=1.
- a=0x10, b=0x0F, bin=1 → diff=0x00, bout=0. Then a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
- Start accepted with a=0x05, b=0x03; at RUN bit 3 drive start=1 with a=0xAA, b=0x11 → ignored, completes with diff=0x02. In a second run, pull rst_n low during bit 4 → done never pulses, diff=0, bout=0, ready=1 while reset is asserted.
- start held high for three operations (0x09−0x04, 0x04−0x09, 0xFF−0xFF) → done pulses exactly 10 cycles apart; diff sequence 0x05, 0xFB, 0x00; bout sequence 0, 1, 0.
